// File: rtl/negate_accumulator_if.sv
// Operand/result bundle for negate_accumulator: operand handshake in, accumulator state out.
interface negate_accumulator_if #(
  parameter int N     = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [N-1:0]     din;
  logic [N-1:0]     acc;
  logic             out_valid;
  logic             V;
  logic             V_sticky;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, op, din,
    input  in_ready, acc, out_valid, V, V_sticky, op_count
  );

  modport slave (
    input  in_valid, op, din,
    output in_ready, acc, out_valid, V, V_sticky, op_count
  );
endinterface

// File: rtl/negate_accumulator.sv
// Two-stage signed add/subtract accumulator; subtract routes the operand through a negate stage.
// Optional build macro SATURATE_EN: clamp acc on overflow instead of wrapping.

// Two's-complement negate; v_o flags the single unrepresentable input -2^(N-1).
module negate #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  output logic [N-1:0] y_o,
  output logic         v_o
);
  assign y_o = ~a_i + N'(1);
  assign v_o = (a_i == {1'b1, {(N-1){1'b0}}});
endmodule

module negate_accumulator #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  negate_accumulator_if.slave  bus
);
  logic [N-1:0]     neg_y;
  logic             neg_v;

  logic             s1_v_q, s1_v_d;
  logic [N-1:0]     s1_b_q, s1_b_d;
  logic             s1_nv_q, s1_nv_d;
  logic [N-1:0]     acc_q, acc_d;
  logic             v_q, v_d;
  logic             v_sticky_q, v_sticky_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [N:0]       b_ext;
  logic [N:0]       r;
  logic             ovf;

  negate #(.N(N)) u_negate (
    .a_i (bus.din),
    .y_o (neg_y),
    .v_o (neg_v)
  );

  assign bus.in_ready = ~clr;

  // Exact (N+1)-bit sum; -(-2^(N-1)) is supplied as +2^(N-1), which fits in N+1 bits.
  assign b_ext = s1_nv_q ? {2'b01, {(N-1){1'b0}}} : {s1_b_q[N-1], s1_b_q};
  assign r     = {acc_q[N-1], acc_q} + b_ext;
  assign ovf   = r[N] ^ r[N-1];

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    s1_v_d      = bus.in_valid & bus.in_ready;
    s1_b_d      = bus.op ? neg_y : bus.din;
    s1_nv_d     = bus.op & neg_v;
    acc_d       = acc_q;
    v_d         = v_q;
    v_sticky_d  = v_sticky_q;
    out_valid_d = 1'b0;
    op_count_d  = op_count_q;

    if (s1_v_q) begin
`ifdef SATURATE_EN
      if (ovf) acc_d = r[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      else     acc_d = r[N-1:0];
`else
      acc_d = r[N-1:0];
`endif
      v_d         = ovf;
      v_sticky_d  = v_sticky_q | ovf;
      out_valid_d = 1'b1;
      op_count_d  = op_count_q + CNT_W'(1);
    end

    // Flush discards the in-flight operand as well as all accumulated state.
    if (clr) begin
      s1_v_d      = 1'b0;
      acc_d       = '0;
      v_d         = 1'b0;
      v_sticky_d  = 1'b0;
      out_valid_d = 1'b0;
      op_count_d  = '0;
    end
  end

  // NOTE: state updates use non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s1_b_q      <= '0;
      s1_nv_q     <= 1'b0;
      acc_q       <= '0;
      v_q         <= 1'b0;
      v_sticky_q  <= 1'b0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_b_q      <= s1_b_d;
      s1_nv_q     <= s1_nv_d;
      acc_q       <= acc_d;
      v_q         <= v_d;
      v_sticky_q  <= v_sticky_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.acc       = acc_q;
  assign bus.V         = v_q;
  assign bus.V_sticky  = v_sticky_q;
  assign bus.out_valid = out_valid_q;
  assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_negate_accumulator.sv
// Directed table-driven bench for negate_accumulator (N=8), wrap or SATURATE_EN build.
module tb_negate_accumulator;
  localparam int N     = 8;
  localparam int CNT_W = 16;
`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic       clr;
    logic       vld;
    logic       op;
    logic [7:0] din;
    logic [7:0] exp_acc;
    logic       exp_ov;
    logic       exp_v;
    logic       exp_vs;
    logic [15:0] exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl [22];

  negate_accumulator_if #(.N(N), .CNT_W(CNT_W)) bus ();

  negate_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic v, input logic o, input logic [7:0] d);
    clr          = c;
    bus.in_valid = v;
    bus.op       = o;
    bus.din      = d;
  endtask

  task automatic check_state(input string tag, input logic [7:0] a, input logic ov,
                             input logic v, input logic vs, input logic [15:0] cnt);
    check({tag, " acc"},       32'(bus.acc),       32'(a));
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'(ov));
    check({tag, " V"},         32'(bus.V),         32'(v));
    check({tag, " V_sticky"},  32'(bus.V_sticky),  32'(vs));
    check({tag, " op_count"},  32'(bus.op_count),  32'(cnt));
  endtask

  initial begin
    logic [7:0] a5, a10, a19;
    a5  = SAT ? 8'h7F : 8'h87;  // 7 - (-128) = 135
    a10 = SAT ? 8'h7F : 8'h80;  // 127 + 1 = 128
    a19 = SAT ? 8'h80 : 8'h7F;  // -128 - 1 = -129

    //           clr  vld  op   din    acc    ov   V    Vs   cnt
    tbl[0]  = '{1'b0,1'b0,1'b0,8'h00, 8'h00, 1'b0,1'b0,1'b0,16'd0};
    tbl[1]  = '{1'b0,1'b1,1'b0,8'h03, 8'h00, 1'b0,1'b0,1'b0,16'd0};
    tbl[2]  = '{1'b0,1'b1,1'b0,8'h04, 8'h03, 1'b1,1'b0,1'b0,16'd1};
    tbl[3]  = '{1'b0,1'b0,1'b0,8'h00, 8'h07, 1'b1,1'b0,1'b0,16'd2};
    tbl[4]  = '{1'b0,1'b1,1'b1,8'h80, 8'h07, 1'b0,1'b0,1'b0,16'd2};
    tbl[5]  = '{1'b0,1'b0,1'b0,8'h00, a5,    1'b1,1'b1,1'b1,16'd3};
    tbl[6]  = '{1'b0,1'b0,1'b0,8'h00, a5,    1'b0,1'b1,1'b1,16'd3};
    tbl[7]  = '{1'b1,1'b0,1'b0,8'h00, 8'h00, 1'b0,1'b0,1'b0,16'd0};
    tbl[8]  = '{1'b0,1'b1,1'b0,8'h7F, 8'h00, 1'b0,1'b0,1'b0,16'd0};
    tbl[9]  = '{1'b0,1'b1,1'b0,8'h01, 8'h7F, 1'b1,1'b0,1'b0,16'd1};
    tbl[10] = '{1'b0,1'b0,1'b0,8'h00, a10,   1'b1,1'b1,1'b1,16'd2};
    tbl[11] = '{1'b1,1'b0,1'b0,8'h00, 8'h00, 1'b0,1'b0,1'b0,16'd0};
    tbl[12] = '{1'b0,1'b1,1'b1,8'h04, 8'h00, 1'b0,1'b0,1'b0,16'd0};
    tbl[13] = '{1'b0,1'b1,1'b1,8'hFC, 8'hFC, 1'b1,1'b0,1'b0,16'd1};
    tbl[14] = '{1'b0,1'b0,1'b0,8'h00, 8'h00, 1'b1,1'b0,1'b0,16'd2};
    tbl[15] = '{1'b0,1'b0,1'b0,8'h00, 8'h00, 1'b0,1'b0,1'b0,16'd2};
    tbl[16] = '{1'b1,1'b0,1'b0,8'h00, 8'h00, 1'b0,1'b0,1'b0,16'd0};
    tbl[17] = '{1'b0,1'b1,1'b0,8'h80, 8'h00, 1'b0,1'b0,1'b0,16'd0};
    tbl[18] = '{1'b0,1'b1,1'b1,8'h01, 8'h80, 1'b1,1'b0,1'b0,16'd1};
    tbl[19] = '{1'b0,1'b1,1'b0,8'h00, a19,   1'b1,1'b1,1'b1,16'd2};
    tbl[20] = '{1'b0,1'b0,1'b0,8'h00, a19,   1'b1,1'b0,1'b1,16'd3};
    tbl[21] = '{1'b0,1'b0,1'b0,8'h00, a19,   1'b0,1'b0,1'b1,16'd3};

    // Reset for two cycles with a live operand that must be ignored.
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'h55);
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check_state("reset", 8'h00, 1'b0, 1'b0, 1'b0, 16'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);

    // Each row: drive inputs, take one edge, compare state registered at that edge.
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].clr, tbl[i].vld, tbl[i].op, tbl[i].din);
      step();
      check_state($sformatf("row%0d", i), tbl[i].exp_acc, tbl[i].exp_ov,
                  tbl[i].exp_v, tbl[i].exp_vs, tbl[i].exp_cnt);
    end

    // clr in the same cycle as a new operand, with another operand already in stage 1.
    drive(1'b0, 1'b1, 1'b0, 8'h05);
    step();
    drive(1'b1, 1'b1, 1'b0, 8'h09);
    #1;
    check("clr in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check_state("clr edge", 8'h00, 1'b0, 1'b0, 1'b0, 16'd0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    check("post clr in_ready", 32'(bus.in_ready), 32'd1);
    step();
    check_state("clr +1", 8'h00, 1'b0, 1'b0, 1'b0, 16'd0);
    step();
    check_state("clr +2", 8'h00, 1'b0, 1'b0, 1'b0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
